// File: rtl/vec_elem_tx_if.sv
// Element transmitter bus: command, VRF read port and the outgoing valid/ready element stream.
// master is the transmitter side; slave is the command source, VRF and element consumer.
interface vec_elem_tx_if #(
  parameter int els_p   = 32,
  parameter int vlen_p  = 8,
  parameter int vdw_p   = 32,
  parameter int lanes_p = 4
);
  localparam int v_addr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int groups_lp       = vlen_p / lanes_p;
  localparam int grp_width_lp    = (groups_lp <= 1) ? 1 : $clog2(groups_lp);

  logic                         cmd_v_i;
  logic [v_addr_width_lp-1:0]   cmd_vaddr_i;
  logic                         cmd_ready_o;
  logic                         rd_v_o;
  logic [v_addr_width_lp-1:0]   rd_vaddr_o;
  logic [grp_width_lp-1:0]      rd_group_o;
  logic [lanes_p*vdw_p-1:0]     rd_data_i;
  logic [vdw_p-1:0]             element_o;
  logic                         v_o;
  logic                         ready_i;
  logic                         last_o;
  logic                         busy_o;

  modport master (
    input  cmd_v_i, cmd_vaddr_i, rd_data_i, ready_i,
    output cmd_ready_o, rd_v_o, rd_vaddr_o, rd_group_o,
           element_o, v_o, last_o, busy_o
  );

  modport slave (
    output cmd_v_i, cmd_vaddr_i, rd_data_i, ready_i,
    input  cmd_ready_o, rd_v_o, rd_vaddr_o, rd_group_o,
           element_o, v_o, last_o, busy_o
  );
endinterface

// File: rtl/vec_elem_tx.sv
// Reads one vector register from the VRF a lane group at a time and serializes
// its elements, element 0 first, onto a valid/ready stream.
module vec_elem_tx #(
  parameter int els_p   = 32,
  parameter int vlen_p  = 8,
  parameter int vdw_p   = 32,
  parameter int lanes_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  vec_elem_tx_if.master      bus
);
  localparam int v_addr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int groups_lp       = vlen_p / lanes_p;
  localparam int grp_width_lp    = (groups_lp <= 1) ? 1 : $clog2(groups_lp);
  localparam int idx_width_lp    = (lanes_p <= 1) ? 1 : $clog2(lanes_p);

  localparam logic [idx_width_lp-1:0] idx_last_lp = idx_width_lp'(lanes_p - 1);
  localparam logic [grp_width_lp-1:0] grp_last_lp = grp_width_lp'(groups_lp - 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_e;

  state_e                          state_r, state_n;
  logic [v_addr_width_lp-1:0]      vaddr_r;
  logic [grp_width_lp-1:0]         group_r;
  logic [idx_width_lp-1:0]         idx_r;
  logic [lanes_p-1:0][vdw_p-1:0]   buf_r;

  logic accept, xfer, lane_done, grp_done;

  assign accept    = (state_r == IDLE) & bus.cmd_v_i;
  assign xfer      = (state_r == SEND) & bus.ready_i;
  assign lane_done = (idx_r == idx_last_lp);
  assign grp_done  = (group_r == grp_last_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (accept) state_n = RD;
      RD:      state_n = CAP;
      CAP:     state_n = SEND;
      SEND:    if (xfer && lane_done) state_n = grp_done ? IDLE : RD;
      default: state_n = IDLE;
    endcase
  end

  // Counters only advance on an accepted transfer and stop at their limits;
  // the next group or command reloads them rather than letting them wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vaddr_r <= '0;
      group_r <= '0;
      idx_r   <= '0;
      buf_r   <= '0;
    end else begin
      if (accept) begin
        vaddr_r <= bus.cmd_vaddr_i;
        group_r <= '0;
      end
      if (state_r == CAP) begin
        buf_r <= bus.rd_data_i;
        idx_r <= '0;
      end
      if (xfer) begin
        if (!lane_done)     idx_r   <= idx_r + idx_width_lp'(1);
        else if (!grp_done) group_r <= group_r + grp_width_lp'(1);
      end
    end
  end

  // Outputs decode straight from the state register so that reset clears
  // v_o and rd_v_o the moment it is asserted.
  always_comb begin
    bus.cmd_ready_o = (state_r == IDLE);
    bus.busy_o      = (state_r != IDLE);
    bus.rd_v_o      = (state_r == RD);
    bus.rd_vaddr_o  = vaddr_r;
    bus.rd_group_o  = group_r;
    bus.v_o         = (state_r == SEND);
    bus.element_o   = '0;
    bus.last_o      = 1'b0;
    if (state_r == SEND) begin
      bus.element_o = buf_r[idx_r];
      bus.last_o    = lane_done & grp_done;
    end
  end
endmodule

// File: tb/tb_vec_elem_tx.sv
// Bench for vec_elem_tx: a four-lane instance driven through directed and random
// commands against an element-queue model, plus a single-group instance.
module tb_vec_elem_tx;
  localparam int VLEN    = 8;
  localparam int LANES_A = 4;
  localparam int GROUPS  = VLEN / LANES_A;
  localparam int LANES_B = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  vec_elem_tx_if #(.els_p(32), .vlen_p(VLEN), .vdw_p(32), .lanes_p(LANES_A)) ba ();
  vec_elem_tx_if #(.els_p(32), .vlen_p(VLEN), .vdw_p(32), .lanes_p(LANES_B)) bb ();

  vec_elem_tx #(.els_p(32), .vlen_p(VLEN), .vdw_p(32), .lanes_p(LANES_A)) dut_a (
    .clk_i(clk), .reset_i(reset), .bus(ba)
  );
  vec_elem_tx #(.els_p(32), .vlen_p(VLEN), .vdw_p(32), .lanes_p(LANES_B)) dut_b (
    .clk_i(clk), .reset_i(reset), .bus(bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRF models: element value is 100*vaddr + element index, presented for exactly
  // the cycle after the read strobe; any other cycle carries random junk.
  logic       a_pv, b_pv;
  logic [4:0] a_pa, b_pa;
  logic       a_pg, b_pg;
  always @(negedge clk) begin
    a_pv = ba.rd_v_o; a_pa = ba.rd_vaddr_o; a_pg = ba.rd_group_o;
    b_pv = bb.rd_v_o; b_pa = bb.rd_vaddr_o; b_pg = bb.rd_group_o;
  end
  always @(posedge clk) begin
    logic [LANES_A*32-1:0] da;
    logic [LANES_B*32-1:0] db;
    #1;
    for (int j = 0; j < LANES_A; j++)
      da[j*32 +: 32] = a_pv ? 32'(100*int'(a_pa) + int'(a_pg)*LANES_A + j) : $urandom;
    for (int j = 0; j < LANES_B; j++)
      db[j*32 +: 32] = b_pv ? 32'(100*int'(b_pa) + int'(b_pg)*LANES_B + j) : $urandom;
    ba.rd_data_i = da;
    bb.rd_data_i = db;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Issue one command on instance A and follow it cycle by cycle against the
  // expected element queue. rmode: 0 ready always high, 1 pattern 1,0,0, 2 random.
  task automatic applyStimulus(input int va, input int rmode, input bit keep_cmd,
                               input int keep_va, input int abort_k);
    int   exp_q[$];
    int   k, c, rdn, vcnt;
    bit   r, prev_hold;
    logic [31:0] prev_el;
    logic prev_last;
    for (int i = 0; i < VLEN; i++) exp_q.push_back(100*va + i);
    ba.cmd_v_i     = 1'b1;
    ba.cmd_vaddr_i = 5'(va);
    checkOutput("cmd_ready_idle", 32'(ba.cmd_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ba.cmd_v_i     = keep_cmd;
    ba.cmd_vaddr_i = 5'(keep_va);
    k = 0; c = 1; rdn = 0; vcnt = 0; prev_hold = 1'b0; prev_el = '0; prev_last = 1'b0;
    while (exp_q.size() > 0 && c < 400) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = ((c - 1) % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ba.ready_i = r;
      checkOutput("cmd_ready_busy", 32'(ba.cmd_ready_o), 32'd0);
      if (ba.rd_v_o) begin
        checkOutput("rd_vaddr", 32'(ba.rd_vaddr_o), 32'(va));
        checkOutput("rd_group", 32'(ba.rd_group_o), 32'(rdn));
        if (rmode == 0) checkOutput("rd_cycle", 32'(c), 32'(1 + rdn*(LANES_A + 2)));
        rdn++;
      end
      if (prev_hold) begin
        checkOutput("hold_v", 32'(ba.v_o), 32'd1);
        checkOutput("hold_element", ba.element_o, prev_el);
        checkOutput("hold_last", 32'(ba.last_o), 32'(prev_last));
      end
      if (ba.v_o) vcnt++;
      if (ba.v_o && r) begin
        checkOutput("element", ba.element_o, 32'(exp_q.pop_front()));
        checkOutput("last", 32'(ba.last_o), 32'(k == VLEN - 1));
        if (rmode == 0)
          checkOutput("xfer_cycle", 32'(c), 32'(3 + (k/LANES_A)*(LANES_A + 2) + k%LANES_A));
        k++;
      end
      prev_hold = ba.v_o && !r;
      prev_el   = ba.element_o;
      prev_last = ba.last_o;
      if (abort_k > 0 && k == abort_k) return;
      if (exp_q.size() > 0) begin
        @(negedge clk);
        c++;
      end
    end
    if (exp_q.size() > 0) checkOutput("timeout_elements", 32'(k), 32'(VLEN));
    checkOutput("rd_count", 32'(rdn), 32'(GROUPS));
    if (rmode == 0) checkOutput("v_cycles", 32'(vcnt), 32'(VLEN));
    @(negedge clk);
    checkOutput("after_ready", 32'(ba.cmd_ready_o), 32'd1);
    checkOutput("after_busy", 32'(ba.busy_o), 32'd0);
    checkOutput("after_v", 32'(ba.v_o), 32'd0);
  endtask

  initial begin
    int kb, cb, rdb;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    ba.cmd_v_i = 1'b0; ba.cmd_vaddr_i = '0; ba.ready_i = 1'b0; ba.rd_data_i = '0;
    bb.cmd_v_i = 1'b0; bb.cmd_vaddr_i = '0; bb.ready_i = 1'b0; bb.rd_data_i = '0;

    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(ba.cmd_ready_o), 32'd1);
    checkOutput("rst_busy", 32'(ba.busy_o), 32'd0);
    checkOutput("rst_v", 32'(ba.v_o), 32'd0);
    checkOutput("rst_rd_v", 32'(ba.rd_v_o), 32'd0);
    checkOutput("rst_last", 32'(ba.last_o), 32'd0);
    checkOutput("rst_element", ba.element_o, 32'd0);
    checkOutput("rst_rd_vaddr", 32'(ba.rd_vaddr_o), 32'd0);
    checkOutput("rst_rd_group", 32'(ba.rd_group_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] idle with ready high");
    ba.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("idle_v", 32'(ba.v_o), 32'd0);
      checkOutput("idle_rd_v", 32'(ba.rd_v_o), 32'd0);
      checkOutput("idle_cmd_ready", 32'(ba.cmd_ready_o), 32'd1);
      checkOutput("idle_busy", 32'(ba.busy_o), 32'd0);
    end

    $display("[TB] basic transfer and backpressure");
    applyStimulus(5, 0, 1'b0, 0, 0);
    applyStimulus(6, 1, 1'b0, 0, 0);

    $display("[TB] command held while busy");
    applyStimulus(2, 0, 1'b1, 9, 0);
    applyStimulus(9, 0, 1'b0, 0, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(3, 0, 1'b0, 0, 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_v", 32'(ba.v_o), 32'd0);
    checkOutput("midrst_rd_v", 32'(ba.rd_v_o), 32'd0);
    checkOutput("midrst_busy", 32'(ba.busy_o), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(ba.cmd_ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postrst_v", 32'(ba.v_o), 32'd0);
    applyStimulus(4, 0, 1'b0, 0, 0);

    $display("[TB] random commands");
    for (int n = 0; n < 8; n++) begin
      applyStimulus(int'($urandom_range(0, 31)), 2, 1'b0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] single-group instance");
    bb.cmd_v_i = 1'b1;
    bb.cmd_vaddr_i = 5'd31;
    checkOutput("b_cmd_ready", 32'(bb.cmd_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bb.cmd_v_i = 1'b0;
    bb.ready_i = 1'b1;
    kb = 0; cb = 1; rdb = 0;
    while (kb < VLEN && cb < 60) begin
      if (bb.rd_v_o) begin
        checkOutput("b_rd_group", 32'(bb.rd_group_o), 32'd0);
        checkOutput("b_rd_vaddr", 32'(bb.rd_vaddr_o), 32'd31);
        rdb++;
      end
      if (bb.v_o) begin
        checkOutput("b_element", bb.element_o, 32'(3100 + kb));
        checkOutput("b_last", 32'(bb.last_o), 32'(kb == VLEN - 1));
        checkOutput("b_xfer_cycle", 32'(cb), 32'(3 + kb));
        kb++;
      end
      @(negedge clk);
      cb++;
    end
    if (kb < VLEN) checkOutput("b_timeout", 32'(kb), 32'(VLEN));
    checkOutput("b_after_ready", 32'(bb.cmd_ready_o), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (bb.rd_v_o) rdb++;
    end
    checkOutput("b_rd_count", 32'(rdb), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vec_elem_tx.md
Name: vec_elem_tx

Overview:
- Transmit end of the vector unit's element stream.
- Accepts a command naming one vector register.
- Reads that register from the VRF, lanes_p elements per read access.
- Serializes the elements onto a valid/ready element interface, element 0 first.
- Its element_o/v_o/ready_i connect directly to a vector-unit element input (element_i/v_i/ready_o), or to any downstream consumer of that protocol.

Parameters:
- els_p, 32: number of vector registers in the VRF.
- vlen_p, 8: elements per vector. Must be a multiple of lanes_p.
- vdw_p, 32: bits per element.
- lanes_p, 4: elements returned per VRF read.
- Derived (localparam) v_addr_width_lp = BSG_SAFE_CLOG2(els_p).
- Derived (localparam) groups_lp = vlen_p/lanes_p.
- Derived (localparam) grp_width_lp = BSG_SAFE_CLOG2(groups_lp).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_v_i  in  1  command valid.
- cmd_vaddr_i  in  v_addr_width_lp  vector register to transmit.
- cmd_ready_o  out  1  block idle; command accepted when cmd_v_i & cmd_ready_o.
- rd_v_o  out  1  VRF read strobe.
- rd_vaddr_o  out  v_addr_width_lp  VRF read vector address.
- rd_group_o  out  grp_width_lp  lane group index (elements group*lanes_p .. +lanes_p-1).
- rd_data_i  in  lanes_p*vdw_p  read data, valid exactly 1 cycle after rd_v_o. Lane j is at [j*vdw_p +: vdw_p].
- element_o  out  vdw_p  element being offered.
- v_o  out  1  element valid.
- ready_i  in  1  consumer ready; transfer occurs when v_o & ready_i.
- last_o  out  1  high with v_o on element vlen_p-1.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted and after release:
  - state = IDLE.
  - cmd_ready_o = 1; busy_o = 0.
  - v_o = 0; rd_v_o = 0; last_o = 0.
  - element buffer, rd_vaddr_o, rd_group_o and element_o are all 0.
- Registers: state, vaddr_r, group_r, idx_r (lane index), buf_r (lanes_p x vdw_p).
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_v_i: vaddr_r <= cmd_vaddr_i, group_r <= 0, go RD.
- RD (exactly 1 cycle):
  - rd_v_o = 1, rd_vaddr_o = vaddr_r, rd_group_o = group_r.
  - Go CAP.
- CAP (exactly 1 cycle):
  - buf_r <= rd_data_i, idx_r <= 0.
  - Go SEND.
- SEND:
  - v_o = 1, element_o = buf_r[idx_r].
  - last_o = (group_r==groups_lp-1) & (idx_r==lanes_p-1).
  - On ready_i with idx_r < lanes_p-1: idx_r++.
  - On ready_i with idx_r == lanes_p-1:
    - last group: go IDLE.
    - otherwise: group_r++, go RD.
- Handshake rules:
  - Once v_o rises, it stays high and element_o/last_o stay stable until ready_i. No retraction.
  - ready_i is ignored while v_o = 0.
  - cmd_v_i is ignored whenever cmd_ready_o = 0. No queueing, no error.
- Latency, with the command accepted in cycle 0:
  - rd_v_o in cycle 1.
  - data captured at the end of cycle 2.
  - first v_o in cycle 3.
- Throughput with ready_i held high:
  - lanes_p elements per lanes_p+2 cycles.
  - full vector in groups_lp*(lanes_p+2) cycles after acceptance.
- Back-to-back commands:
  - The cycle after the last transfer, state is IDLE and cmd_ready_o = 1.
  - A new command may be accepted that cycle.
- groups_lp = 1 (lanes_p == vlen_p): grp_width_lp = 1, rd_group_o is always 0, a single RD per command.
- Reset mid-operation: transfer is abandoned. v_o and rd_v_o drop immediately (asynchronously). No partial resume after release.
- No arithmetic beyond counters. idx_r and group_r never wrap past their limits; they reset to 0 per group and per command respectively.

Test Plan:
- Basic transfer (vlen_p=8, lanes_p=4):
  - Stimulus: ready_i held 1; cmd vaddr=5; VRF model returns element value = 100*vaddr + element index.
  - Required: rd_v_o in cycles 1 and 7 with rd_group_o 0 then 1.
  - Required: element_o sequence 500..507 on v_o in cycles 3-6 and 9-12; last_o only with 507.
- Backpressure:
  - Stimulus: ready_i toggles 1,0,0,1,...
  - Required: element_o/v_o held stable during low cycles; all 8 elements delivered once, in order, no duplicates.
- Busy command:
  - Stimulus: cmd_v_i with vaddr=9 asserted throughout a transfer of vaddr=2.
  - Required: cmd_ready_o=0 until the cycle after element 7 transfers; vaddr=9 is then accepted and streams 900..907.
- Reset mid-stream:
  - Stimulus: assert reset_i (asynchronously, mid-cycle) after element 2 of vaddr=3.
  - Required: v_o=0, busy_o=0, cmd_ready_o=1 immediately.
  - Required: after release, a new cmd vaddr=4 yields 400..407 from element 0.
- Single-group configuration:
  - Stimulus: lanes_p=vlen_p=8, cmd vaddr=31.
  - Required: exactly one rd_v_o pulse; 3100..3107 streamed; last_o on 3107.
- Idle ready_i:
  - Stimulus: ready_i=1 with no command.
  - Required: v_o and rd_v_o stay 0; no state change.
